// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath/memory.
// The master side is the controller; the slave side is the datapath and memory.
interface multicycle_controller_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic        alu_src_b;
  logic [2:0]  imm_type;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        trap;
  logic        trap_cause;

  // Memory handshake: mem_req is held until a cycle with mem_req=1 and
  // mem_ready=1 completes the transfer; that cycle is the only one that advances.
  modport master (
    input  instr, mem_ready, branch_taken,
    output ir_we, pc_we, pc_src, alu_src_a, alu_src_b, imm_type, mem_req,
           mem_we, mem_addr_sel, reg_we, wb_sel, state, trap, trap_cause
  );

  modport slave (
    output instr, mem_ready, branch_taken,
    input  ir_we, pc_we, pc_src, alu_src_a, alu_src_b, imm_type, mem_req,
           mem_we, mem_addr_sel, reg_we, wb_sel, state, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath with a
// shared memory port, a memory wait timeout and a sticky trap state.
module multicycle_controller #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_R, OP_IALU, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH,
    OP_LUI, OP_AUIPC, OP_JAL, OP_ILL
  } op_t;

  state_t     r_state;
  logic [7:0] r_wait;
  logic       r_trap;
  logic       r_trap_cause;

  op_t        w_op;
  logic [2:0] w_imm;
  logic       w_wait_hit;
  logic       w_unused_instr;

  logic       w_ir_we, w_pc_we, w_alu_src_a, w_alu_src_b;
  logic       w_mem_req, w_mem_we, w_mem_addr_sel, w_reg_we;
  logic       w_trap, w_trap_cause;
  logic [1:0] w_pc_src, w_wb_sel;
  logic [2:0] w_imm_type, w_state;

  assign w_unused_instr = ^bus.instr[31:7];

  always_comb begin
    w_op = OP_ILL;
    case (bus.instr[6:0])
      7'b0110011: w_op = OP_R;
      7'b0010011: w_op = OP_IALU;
      7'b0000011: w_op = OP_LOAD;
      7'b1100111: w_op = OP_JALR;
      7'b0100011: w_op = OP_STORE;
      7'b1100011: w_op = OP_BRANCH;
      7'b0110111: w_op = OP_LUI;
      7'b0010111: w_op = OP_AUIPC;
      7'b1101111: w_op = OP_JAL;
      default:    w_op = OP_ILL;
    endcase
  end

  always_comb begin
    w_imm = 3'd0;
    case (w_op)
      OP_IALU, OP_LOAD, OP_JALR: w_imm = 3'd1;
      OP_STORE:                  w_imm = 3'd2;
      OP_BRANCH:                 w_imm = 3'd3;
      OP_LUI, OP_AUIPC:          w_imm = 3'd4;
      OP_JAL:                    w_imm = 3'd5;
      default:                   w_imm = 3'd0;
    endcase
  end

  // r_wait counts completed wait cycles, so this cycle is wait number WAIT_MAX.
  assign w_wait_hit = (r_wait == 8'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_wait       <= 8'd0;
      r_trap       <= 1'b0;
      r_trap_cause <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH, S_MEM: begin
          if (bus.mem_ready) begin
            r_wait <= 8'd0;
            if (r_state == S_FETCH)    r_state <= S_DECODE;
            else if (w_op == OP_LOAD)  r_state <= S_WB;
            else                       r_state <= S_FETCH;
          end else if (w_wait_hit) begin
            r_wait       <= 8'd0;
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          if (w_op == OP_ILL) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= 1'b0;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_op == OP_BRANCH)                           r_state <= S_FETCH;
          else if (w_op == OP_LOAD || w_op == OP_STORE)    r_state <= S_MEM;
          else                                             r_state <= S_WB;
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from the current state; reset forces every one of them low.
  always_comb begin
    w_ir_we        = 1'b0;
    w_pc_we        = 1'b0;
    w_pc_src       = 2'd0;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = 1'b0;
    w_imm_type     = 3'd0;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_reg_we       = 1'b0;
    w_wb_sel       = 2'd0;
    w_state        = 3'd0;
    w_trap         = 1'b0;
    w_trap_cause   = 1'b0;
    if (!reset) begin
      w_state      = r_state;
      w_trap       = r_trap;
      w_trap_cause = r_trap_cause;
      case (r_state)
        S_FETCH: begin
          w_mem_req = 1'b1;
          w_ir_we   = bus.mem_ready;
        end
        S_DECODE: w_imm_type = w_imm;
        S_EXEC: begin
          w_imm_type  = w_imm;
          w_alu_src_b = (w_op != OP_R) && (w_op != OP_BRANCH);
          w_alu_src_a = (w_op == OP_AUIPC);
          if (w_op == OP_BRANCH) begin
            w_pc_we  = 1'b1;
            w_pc_src = bus.branch_taken ? 2'd1 : 2'd0;
          end
        end
        S_MEM: begin
          w_imm_type     = w_imm;
          w_mem_req      = 1'b1;
          w_mem_addr_sel = 1'b1;
          w_mem_we       = (w_op == OP_STORE);
          w_pc_we        = (w_op == OP_STORE) && bus.mem_ready;
        end
        S_WB: begin
          w_imm_type = w_imm;
          w_reg_we   = 1'b1;
          w_pc_we    = 1'b1;
          case (w_op)
            OP_LOAD: w_wb_sel = 2'd1;
            OP_JAL:  begin w_wb_sel = 2'd2; w_pc_src = 2'd1; end
            OP_JALR: begin w_wb_sel = 2'd2; w_pc_src = 2'd2; end
            default: w_wb_sel = 2'd0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.ir_we        = w_ir_we;
  assign bus.pc_we        = w_pc_we;
  assign bus.pc_src       = w_pc_src;
  assign bus.alu_src_a    = w_alu_src_a;
  assign bus.alu_src_b    = w_alu_src_b;
  assign bus.imm_type     = w_imm_type;
  assign bus.mem_req      = w_mem_req;
  assign bus.mem_we       = w_mem_we;
  assign bus.mem_addr_sel = w_mem_addr_sel;
  assign bus.reg_we       = w_reg_we;
  assign bus.wb_sel       = w_wb_sel;
  assign bus.state        = w_state;
  assign bus.trap         = w_trap;
  assign bus.trap_cause   = w_trap_cause;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table for the
// instruction classes, plus hand-written reset, illegal-opcode and timeout runs.
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0] state;
    logic       trap;
    logic       trap_cause;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] imm_type;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        rdy;
    logic        bt;
    outs_t       exp;
  } vec_t;

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] SW    = 32'h00112023;
  localparam logic [31:0] BEQ   = 32'h00000463;
  localparam logic [31:0] LUI   = 32'h000010B7;
  localparam logic [31:0] AUIPC = 32'h00000097;
  localparam logic [31:0] JAL   = 32'h0000006F;
  localparam logic [31:0] JALR  = 32'h000080E7;
  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] ILL   = 32'h0000007F;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  vec_t tbl[$];
  outs_t z_o, f_ok, f_wt;

  multicycle_controller_if bus();

  multicycle_controller #(.WAIT_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Argument order: state, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, imm_type,
  // mem_req, mem_we, mem_addr_sel, reg_we, wb_sel, trap, trap_cause.
  function automatic outs_t mk(input int st, input int ir, input int pcwe, input int pcsrc,
                               input int sa, input int sb, input int imm, input int req,
                               input int mwe, input int asel, input int rwe, input int wbs,
                               input int trp, input int cause);
    outs_t o;
    o.state        = 3'(st);
    o.ir_we        = 1'(ir);
    o.pc_we        = 1'(pcwe);
    o.pc_src       = 2'(pcsrc);
    o.alu_src_a    = 1'(sa);
    o.alu_src_b    = 1'(sb);
    o.imm_type     = 3'(imm);
    o.mem_req      = 1'(req);
    o.mem_we       = 1'(mwe);
    o.mem_addr_sel = 1'(asel);
    o.reg_we       = 1'(rwe);
    o.wb_sel       = 2'(wbs);
    o.trap         = 1'(trp);
    o.trap_cause   = 1'(cause);
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t a;
    a.state        = bus.state;
    a.ir_we        = bus.ir_we;
    a.pc_we        = bus.pc_we;
    a.pc_src       = bus.pc_src;
    a.alu_src_a    = bus.alu_src_a;
    a.alu_src_b    = bus.alu_src_b;
    a.imm_type     = bus.imm_type;
    a.mem_req      = bus.mem_req;
    a.mem_we       = bus.mem_we;
    a.mem_addr_sel = bus.mem_addr_sel;
    a.reg_we       = bus.reg_we;
    a.wb_sel       = bus.wb_sel;
    a.trap         = bus.trap;
    a.trap_cause   = bus.trap_cause;
    return a;
  endfunction

  function automatic void add(input logic rst, input logic [31:0] ins, input logic rdy,
                              input logic bt, input outs_t e);
    vec_t v;
    v.rst   = rst;
    v.instr = ins;
    v.rdy   = rdy;
    v.bt    = bt;
    v.exp   = e;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t act;
    act = sample();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h (state %0d) expected %05h (state %0d)",
               name, act, act.state, exp, exp.state);
    end
  endtask

  // Drive one cycle's inputs just after the edge, check mid-cycle, then clock.
  task automatic apply(input logic rst, input logic [31:0] ins, input logic rdy,
                       input logic bt, input outs_t exp, input string name);
    reset            = rst;
    bus.instr        = ins;
    bus.mem_ready    = rdy;
    bus.branch_taken = bt;
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    reset            = 1'b1;
    bus.instr        = 32'd0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    z_o  = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    f_ok = mk(0,1,0,0,0,0,0,1,0,0,0,0,0,0);
    f_wt = mk(0,0,0,0,0,0,0,1,0,0,0,0,0,0);

    add(1, ADDI, 1, 1, z_o);
    // ADDI: F D E W
    add(0, ADDI, 1, 0, f_ok);
    add(0, ADDI, 1, 0, mk(1,0,0,0,0,0,1,0,0,0,0,0,0,0));
    add(0, ADDI, 1, 0, mk(2,0,0,0,0,1,1,0,0,0,0,0,0,0));
    add(0, ADDI, 1, 0, mk(4,0,1,0,0,0,1,0,0,0,1,0,0,0));
    // BEQ taken, then not taken
    add(0, BEQ, 1, 1, f_ok);
    add(0, BEQ, 1, 1, mk(1,0,0,0,0,0,3,0,0,0,0,0,0,0));
    add(0, BEQ, 1, 1, mk(2,0,1,1,0,0,3,0,0,0,0,0,0,0));
    add(0, BEQ, 1, 0, f_ok);
    add(0, BEQ, 1, 0, mk(1,0,0,0,0,0,3,0,0,0,0,0,0,0));
    add(0, BEQ, 1, 0, mk(2,0,1,0,0,0,3,0,0,0,0,0,0,0));
    // LW with three stall cycles in MEM
    add(0, LW, 1, 0, f_ok);
    add(0, LW, 1, 0, mk(1,0,0,0,0,0,1,0,0,0,0,0,0,0));
    add(0, LW, 1, 0, mk(2,0,0,0,0,1,1,0,0,0,0,0,0,0));
    add(0, LW, 0, 0, mk(3,0,0,0,0,0,1,1,0,1,0,0,0,0));
    add(0, LW, 0, 0, mk(3,0,0,0,0,0,1,1,0,1,0,0,0,0));
    add(0, LW, 0, 0, mk(3,0,0,0,0,0,1,1,0,1,0,0,0,0));
    add(0, LW, 1, 0, mk(3,0,0,0,0,0,1,1,0,1,0,0,0,0));
    add(0, LW, 1, 0, mk(4,0,1,0,0,0,1,0,0,0,1,1,0,0));
    // SW zero-wait
    add(0, SW, 1, 0, f_ok);
    add(0, SW, 1, 0, mk(1,0,0,0,0,0,2,0,0,0,0,0,0,0));
    add(0, SW, 1, 0, mk(2,0,0,0,0,1,2,0,0,0,0,0,0,0));
    add(0, SW, 1, 0, mk(3,0,1,0,0,0,2,1,1,1,0,0,0,0));
    // LUI
    add(0, LUI, 1, 0, f_ok);
    add(0, LUI, 1, 0, mk(1,0,0,0,0,0,4,0,0,0,0,0,0,0));
    add(0, LUI, 1, 0, mk(2,0,0,0,0,1,4,0,0,0,0,0,0,0));
    add(0, LUI, 1, 0, mk(4,0,1,0,0,0,4,0,0,0,1,0,0,0));
    // AUIPC
    add(0, AUIPC, 1, 0, f_ok);
    add(0, AUIPC, 1, 0, mk(1,0,0,0,0,0,4,0,0,0,0,0,0,0));
    add(0, AUIPC, 1, 0, mk(2,0,0,0,1,1,4,0,0,0,0,0,0,0));
    add(0, AUIPC, 1, 0, mk(4,0,1,0,0,0,4,0,0,0,1,0,0,0));
    // JAL
    add(0, JAL, 1, 0, f_ok);
    add(0, JAL, 1, 0, mk(1,0,0,0,0,0,5,0,0,0,0,0,0,0));
    add(0, JAL, 1, 0, mk(2,0,0,0,0,1,5,0,0,0,0,0,0,0));
    add(0, JAL, 1, 0, mk(4,0,1,1,0,0,5,0,0,0,1,2,0,0));
    // R-type ADD, with one fetch stall first
    add(0, ADD, 0, 0, f_wt);
    add(0, ADD, 1, 0, f_ok);
    add(0, ADD, 1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add(0, ADD, 1, 1, mk(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add(0, ADD, 1, 0, mk(4,0,1,0,0,0,0,0,0,0,1,0,0,0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].rst, tbl[i].instr, tbl[i].rdy, tbl[i].bt, tbl[i].exp, $sformatf("vec%0d", i));

    // JALR, then SW aborted by reset while waiting in MEM
    apply(1, JALR, 1, 0, z_o, "jalr_rst");
    apply(0, JALR, 1, 0, f_ok, "jalr_f");
    apply(0, JALR, 1, 0, mk(1,0,0,0,0,0,1,0,0,0,0,0,0,0), "jalr_d");
    apply(0, JALR, 1, 0, mk(2,0,0,0,0,1,1,0,0,0,0,0,0,0), "jalr_e");
    apply(0, JALR, 1, 0, mk(4,0,1,2,0,0,1,0,0,0,1,2,0,0), "jalr_wb");
    apply(0, SW, 1, 0, f_ok, "sw_f");
    apply(0, SW, 1, 0, mk(1,0,0,0,0,0,2,0,0,0,0,0,0,0), "sw_d");
    apply(0, SW, 1, 0, mk(2,0,0,0,0,1,2,0,0,0,0,0,0,0), "sw_e");
    apply(0, SW, 0, 0, mk(3,0,0,0,0,0,2,1,1,1,0,0,0,0), "sw_mem_wait");
    apply(1, SW, 1, 0, z_o, "sw_mem_reset");
    apply(0, SW, 0, 0, f_wt, "sw_after_reset");

    // Illegal opcode: sticky TRAP until reset
    apply(1, ILL, 1, 0, z_o, "ill_rst");
    apply(0, ILL, 1, 0, f_ok, "ill_f");
    apply(0, ILL, 1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "ill_d");
    for (int i = 0; i < 10; i++)
      apply(0, ILL, 1, i[0], mk(7,0,0,0,0,0,0,0,0,0,0,0,1,0), $sformatf("ill_trap%0d", i));
    apply(1, ILL, 1, 1, z_o, "ill_reset");
    apply(0, ADDI, 0, 0, f_wt, "ill_after_reset");

    // Fetch timeout: 15 wait cycles then TRAP with cause 1
    apply(1, ADDI, 0, 0, z_o, "to_rst");
    for (int i = 0; i < 15; i++)
      apply(0, ADDI, 0, 0, f_wt, $sformatf("to_wait%0d", i));
    apply(0, ADDI, 1, 1, mk(7,0,0,0,0,0,0,0,0,0,0,0,1,1), "to_trap");
    apply(0, ADDI, 0, 0, mk(7,0,0,0,0,0,0,0,0,0,0,0,1,1), "to_trap_hold");

    // Ready on the 15th wait cycle wins over the timeout
    apply(1, ADDI, 0, 0, z_o, "to2_rst");
    for (int i = 0; i < 14; i++)
      apply(0, ADDI, 0, 0, f_wt, $sformatf("to2_wait%0d", i));
    apply(0, ADDI, 1, 0, f_ok, "to2_ready");
    apply(0, ADDI, 1, 0, mk(1,0,0,0,0,0,1,0,0,0,0,0,0,0), "to2_decode");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
